psg_env_gen: RTL and testbench

- Envelope generator for the PSG. Sits directly downstream of the programmable period divider.
- Consumes the divider's toggling `div` output as its step clock.
- Produces the stepped amplitude envelope that channels in envelope mode use in place of their fixed volume.
- Implements the 16 shape codes (CONT, ATT, ALT, HOLD), restarted by a write to the shape register.

---
 rtl/psg_env_gen.sv | 86 ++++++++
 tb/tb_psg_env_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/psg_env_gen.sv
// rtl/psg_env_gen.sv - PSG envelope generator: 16 shapes, stepped on divider rising edges
module psg_env_gen #(
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          env_div,
  input  logic [3:0]    ctrl,
  input  logic          restart,
  output logic [SW-1:0] env,
  output logic          env_run
);

  typedef enum logic {STOP, RUN} state_t;

  localparam logic [SW-1:0] MAX_CNT = '1;

  state_t        state;
  logic [SW-1:0] cnt;
  logic          inv;
  logic          div_q;
  logic [3:0]    shape_q;
  logic [SW-1:0] hold_lvl;
  logic          step;
  logic [SW-1:0] lvl;

  // one step per full divider period: rising edge of the divider toggle
  assign step = cen & env_div & ~div_q;
  // inv turns the up-counter into a falling ramp
  assign lvl  = cnt ^ {SW{inv}};

  // shape sequencer: restart wins over any step landing in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= STOP;
      cnt      <= '0;
      inv      <= 1'b0;
      div_q    <= 1'b0;
      shape_q  <= 4'b0000;
      hold_lvl <= '0;
    end else if (restart) begin
      // resync div_q so the current divider level is not mistaken for an edge
      shape_q <= ctrl;
      cnt     <= '0;
      inv     <= ~ctrl[2];
      state   <= RUN;
      div_q   <= env_div;
    end else begin
      if (cen) begin
        div_q <= env_div;
      end
      if (step && state == RUN) begin
        if (cnt != MAX_CNT) begin
          cnt <= cnt + SW'(1);
        end else if (!shape_q[3]) begin
          // non-continuing shapes all park at zero
          state    <= STOP;
          hold_lvl <= '0;
        end else if (shape_q[0]) begin
          // hold: keep the final level, or its complement when ALT is set
          state    <= STOP;
          hold_lvl <= shape_q[1] ? ~lvl : lvl;
        end else begin
          // repeat: sawtooth keeps direction, triangle flips it at the wrap
          cnt <= '0;
          if (shape_q[1]) begin
            inv <= ~inv;
          end
        end
      end
    end
  end

  // registered outputs, one clk behind the sequencer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env     <= '0;
      env_run <= 1'b0;
    end else begin
      env     <= (state == RUN) ? lvl : hold_lvl;
      env_run <= (state == RUN);
    end
  end

endmodule

// File: tb/tb_psg_env_gen.sv
// tb/tb_psg_env_gen.sv - directed self-checking bench for psg_env_gen
module tb_psg_env_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       env_div;
  logic [3:0] ctrl;
  logic       restart;
  logic [4:0] env;
  logic       env_run;

  int checks   = 0;
  int failures = 0;

  psg_env_gen #(.SW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .env_div (env_div),
    .ctrl    (ctrl),
    .restart (restart),
    .env     (env),
    .env_run (env_run)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_env(input string tag, input logic [4:0] exp);
    checks++;
    assert (env === exp) else begin
      failures++;
      $error("FAIL %s env=%0d expected=%0d", tag, env, exp);
    end
  endtask

  task automatic chk_run(input string tag, input logic exp);
    checks++;
    assert (env_run === exp) else begin
      failures++;
      $error("FAIL %s env_run=%0b expected=%0b", tag, env_run, exp);
    end
  endtask

  // one full divider period: rise then fall, env reflects the step afterwards
  task automatic do_step();
    env_div = 1'b1;
    cyc();
    env_div = 1'b0;
    cyc();
  endtask

  task automatic do_restart(input logic [3:0] c);
    ctrl    = c;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n   = 1'b0;
    cen     = 1'b1;
    env_div = 1'b0;
    ctrl    = 4'b0000;
    restart = 1'b0;
    cyc();
    cyc();
    chk_env("reset_env", 5'd0);
    chk_run("reset_run", 1'b0);
    rst_n = 1'b1;
    cyc();
    chk_env("post_reset_env", 5'd0);

    // 1: shape 0000, single falling ramp ending at 0
    do_restart(4'b0000);
    chk_env("s0_start", 5'd31);
    chk_run("s0_start_run", 1'b1);
    cen     = 1'b0;
    env_div = 1'b1;
    cyc();
    env_div = 1'b0;
    cyc();
    chk_env("s0_cen_low", 5'd31);
    cen = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      do_step();
      chk_env("s0_ramp", 5'(31 - k));
      chk_run("s0_ramp_run", 1'b1);
    end
    env_div = 1'b1;
    cyc();
    chk_run("s0_end_run_lag", 1'b1);
    env_div = 1'b0;
    cyc();
    chk_run("s0_end_run", 1'b0);
    chk_env("s0_end_env", 5'd0);
    for (int k = 0; k < 16; k++) begin
      do_step();
      chk_env("s0_stopped", 5'd0);
    end

    // 2: shape 1000, falling sawtooth for more than three ramps
    do_restart(4'b1000);
    chk_env("saw_start", 5'd31);
    for (int k = 1; k <= 100; k++) begin
      do_step();
      chk_env("saw", 5'(31 - (k % 32)));
      chk_run("saw_run", 1'b1);
    end

    // 3: shape 1110, triangle starting upward
    do_restart(4'b1110);
    chk_env("tri_start", 5'd0);
    for (int k = 1; k <= 96; k++) begin
      do_step();
      if (((k / 32) % 2) == 0) chk_env("tri_up", 5'(k % 32));
      else                     chk_env("tri_down", 5'(31 - (k % 32)));
    end

    // 4a: shape 1011, fall then hold at max
    do_restart(4'b1011);
    chk_env("h1011_start", 5'd31);
    for (int k = 1; k <= 31; k++) begin
      do_step();
      chk_env("h1011_ramp", 5'(31 - k));
    end
    do_step();
    chk_env("h1011_hold", 5'd31);
    chk_run("h1011_hold_run", 1'b0);
    ctrl = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      do_step();
      chk_env("h1011_hold_ctrl_chg", 5'd31);
    end

    // 4b: shape 1111, rise then hold at 0
    do_restart(4'b1111);
    chk_env("h1111_start", 5'd0);
    for (int k = 1; k <= 31; k++) begin
      do_step();
      chk_env("h1111_ramp", 5'(k));
    end
    do_step();
    chk_env("h1111_hold", 5'd0);
    chk_run("h1111_hold_run", 1'b0);

    // 5: restart coinciding with a divider rising edge at env=17
    do_restart(4'b0000);
    for (int k = 1; k <= 14; k++) do_step();
    chk_env("coin_pre", 5'd17);
    ctrl    = 4'b0100;
    restart = 1'b1;
    env_div = 1'b1;
    cyc();
    restart = 1'b0;
    cyc();
    chk_env("coin_after", 5'd0);
    chk_run("coin_run", 1'b1);
    env_div = 1'b0;
    cyc();
    chk_env("coin_no_step", 5'd0);
    do_step();
    chk_env("coin_first_step", 5'd1);

    // 6: asynchronous reset mid-ramp at env=12
    do_restart(4'b1000);
    for (int k = 1; k <= 19; k++) do_step();
    chk_env("rst_pre", 5'd12);
    #2 rst_n = 1'b0;
    #1;
    chk_env("rst_async_env", 5'd0);
    chk_run("rst_async_run", 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      do_step();
      chk_env("rst_idle_env", 5'd0);
      chk_run("rst_idle_run", 1'b0);
    end
    do_restart(4'b0000);
    chk_env("rst_restart", 5'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
